// File: rtl/cla_adder_bist_checker.sv
// Built-in self-test response checker for a small carry-lookahead adder.
// Sweeps every {cin,a,b} vector, samples the adder after SETTLE cycles and reports the results.
module cla_adder_bist_checker #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     test_a,
    output logic [WIDTH-1:0]     test_b,
    output logic                 test_cin,
    input  logic [WIDTH-1:0]     dut_sum,
    input  logic                 dut_cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   err_count,
    output logic                 fail_valid,
    output logic [2*WIDTH:0]     fail_vec
);

    localparam int VW = 2*WIDTH+1;
    localparam int EW = 2*WIDTH+2;
    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [VW-1:0]   vec_q, vec_d;
    logic [3:0]      wait_q, wait_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [EW-1:0]   err_q, err_d;
    logic            fvalid_q, fvalid_d;
    logic [VW-1:0]   fvec_q, fvec_d;

    logic [WIDTH:0]  golden;
    logic            mismatch;

    // vec is ordered {cin, a, b}
    assign golden   = {1'b0, vec_q[2*WIDTH-1:WIDTH]} + {1'b0, vec_q[WIDTH-1:0]}
                    + {{WIDTH{1'b0}}, vec_q[VW-1]};
    assign mismatch = ({dut_cout, dut_sum} != golden);

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        wait_d   = wait_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        fvalid_d = fvalid_q;
        fvec_d   = fvec_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    err_d    = '0;
                    fvalid_d = 1'b0;
                    fvec_d   = '0;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    vec_d    = '0;
                    busy_d   = 1'b1;
                    wait_d   = SETTLE_L;
                    state_d  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (wait_q <= 4'd1) begin
                    state_d = S_CHECK;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    err_d = err_q + EW'(1);
                    if (!fvalid_q) begin
                        fvec_d   = vec_q;
                        fvalid_d = 1'b1;
                    end
                end
                if (vec_q == {VW{1'b1}}) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    vec_d   = vec_q + VW'(1);
                    wait_d  = SETTLE_L;
                    state_d = S_DRIVE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            vec_q    <= '0;
            wait_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            fvalid_q <= 1'b0;
            fvec_q   <= '0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            wait_q   <= wait_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            fvalid_q <= fvalid_d;
            fvec_q   <= fvec_d;
        end
    end

    assign test_cin   = vec_q[VW-1];
    assign test_a     = vec_q[2*WIDTH-1:WIDTH];
    assign test_b     = vec_q[WIDTH-1:0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fvalid_q;
    assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_cla_adder_bist_checker.sv
// Directed bench: one checker on a combinational adder with injectable faults,
// a second (SETTLE=3) on a two-stage registered adder.
module tb_cla_adder_bist_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic [1:0] fault = 2'd0;

    logic [1:0] test_a, test_b, dut_sum;
    logic       test_cin, dut_cout;
    logic       busy, done, pass, fail_valid;
    logic [5:0] err_count;
    logic [4:0] fail_vec;

    logic [1:0] test_a2, test_b2;
    logic       test_cin2, busy2, done2, pass2, fail_valid2;
    logic [5:0] err_count2;
    logic [4:0] fail_vec2;
    logic [2:0] pipe1, pipe2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // adder under test, fault 1 = cout stuck-at-0, fault 2 = sum[0] stuck-at-0
    always_comb begin
        logic [2:0] full;
        full = {1'b0, test_a} + {1'b0, test_b} + {2'b00, test_cin};
        if (fault == 2'd1) full[2] = 1'b0;
        if (fault == 2'd2) full[0] = 1'b0;
        dut_sum  = full[1:0];
        dut_cout = full[2];
    end

    always_ff @(posedge clk) begin
        pipe1 <= {1'b0, test_a2} + {1'b0, test_b2} + {2'b00, test_cin2};
        pipe2 <= pipe1;
    end

    cla_adder_bist_checker #(.WIDTH(2), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .test_a(test_a), .test_b(test_b), .test_cin(test_cin),
        .dut_sum(dut_sum), .dut_cout(dut_cout),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .fail_vec(fail_vec)
    );

    cla_adder_bist_checker #(.WIDTH(2), .SETTLE(3)) u_dut_slow (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .test_a(test_a2), .test_b(test_b2), .test_cin(test_cin2),
        .dut_sum(pipe2[1:0]), .dut_cout(pipe2[2]),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
        .fail_valid(fail_valid2), .fail_vec(fail_vec2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Issue start so it is sampled at E0; return #1 after E0.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Walk 64 cycles from E0, checking vector order, busy and done timing.
    // repulse_at >= 0 raises start for one cycle at that offset.
    task automatic run_sweep(input string tag, input int repulse_at, input bit check_order);
        int order_errs = 0;
        int busy_errs = 0;
        for (int i = 0; i < 64; i++) begin
            if ({test_cin, test_a, test_b} != 5'(i / 2)) order_errs++;
            if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0) busy_errs++;
            if (i == repulse_at) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        if (check_order) check_eq({tag, "_vec_order_errs"}, order_errs, 0);
        check_eq({tag, "_busy_window_errs"}, busy_errs, 0);
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_busy_off"}, busy, 0);
    endtask

    initial begin
        #12;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_vec", {test_cin, test_a, test_b}, 0);
        check_eq("rst_err", err_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // correct adder
        fault = 2'd0;
        pulse_start();
        run_sweep("good", -1, 1'b1);
        check_eq("good_pass", pass, 1);
        check_eq("good_err", err_count, 0);
        check_eq("good_fvalid", fail_valid, 0);

        // cout stuck-at-0
        fault = 2'd1;
        pulse_start();
        check_eq("cout_cleared_done", done, 0);
        run_sweep("cout", -1, 1'b0);
        check_eq("cout_pass", pass, 0);
        check_eq("cout_err", err_count, 16);
        check_eq("cout_fvalid", fail_valid, 1);
        check_eq("cout_fvec", fail_vec, 7);

        // sum[0] stuck-at-0
        fault = 2'd2;
        pulse_start();
        run_sweep("sum0", -1, 1'b0);
        check_eq("sum0_pass", pass, 0);
        check_eq("sum0_err", err_count, 16);
        check_eq("sum0_fvec", fail_vec, 1);

        // reset mid-sweep with a failing adder so results are non-zero
        fault = 2'd1;
        pulse_start();
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_vec", {test_cin, test_a, test_b}, 0);
        check_eq("midrst_err", err_count, 0);
        check_eq("midrst_fvalid", fail_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        run_sweep("after_rst", -1, 1'b1);
        check_eq("after_rst_err", err_count, 16);
        check_eq("after_rst_fvec", fail_vec, 7);

        // start re-pulsed while busy is ignored
        fault = 2'd0;
        pulse_start();
        run_sweep("repulse", 10, 1'b1);
        check_eq("repulse_pass", pass, 1);

        // restart out of DONE with err_count=16 clears counts
        fault = 2'd2;
        pulse_start();
        run_sweep("pre_restart", -1, 1'b0);
        check_eq("pre_restart_err", err_count, 16);
        fault = 2'd0;
        pulse_start();
        check_eq("restart_err_clr", err_count, 0);
        check_eq("restart_fvalid_clr", fail_valid, 0);
        check_eq("restart_pass_clr", pass, 0);
        run_sweep("restart", -1, 1'b1);
        check_eq("restart_pass", pass, 1);
        check_eq("restart_err", err_count, 0);

        // SETTLE=3 against a 2-cycle registered adder: done after 128 cycles
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        begin
            int early = 0;
            for (int i = 0; i < 128; i++) begin
                if (done2 !== 1'b0 || busy2 !== 1'b1) early++;
                @(posedge clk);
                #1;
            end
            check_eq("slow_early_done", early, 0);
        end
        check_eq("slow_done", done2, 1);
        check_eq("slow_pass", pass2, 1);
        check_eq("slow_err", err_count2, 0);
        check_eq("slow_fvalid", fail_valid2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cla_adder_bist_checker.md
# cla_adder_bist_checker

Self-checking response engine for the 2-bit carry-lookahead adder. It is the receiving end of the adder's test interface: it sweeps every {Carry_in, A, B} vector into the adder and samples Sum/Carry_out after a programmable settle time. Each response is compared against a golden A+B+Carry_in, and the block reports error count, first failing vector and pass/fail. It sits beside `cla_adder` as a silicon/FPGA built-in self-test, so exhaustive checking no longer depends on waveform inspection.

## Interface
- WIDTH, 2, operand width of the adder under test (A, B, Sum).
- SETTLE, 1, cycles each vector is held before sampling; legal range 1..15.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begins a sweep; sampled only in IDLE or DONE.
- test_a  output  WIDTH  A operand to adder.
- test_b  output  WIDTH  B operand to adder.
- test_cin  output  1  Carry_in to adder.
- dut_sum  input  WIDTH  Sum from adder.
- dut_cout  input  1  Carry_out from adder.
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; level, held until next start or reset.
- pass  output  1  done && err_count==0.
- err_count  output  2*WIDTH+2  number of mismatching vectors.
- fail_valid  output  1  at least one mismatch captured.
- fail_vec  output  2*WIDTH+1  first failing vector {cin,a,b}.

## Operation
- Vector register vec, 2*WIDTH+1 bits, ordered {cin, a, b}; test_cin/test_a/test_b are driven directly from vec. Sweep order is 0 to 2^(2*WIDTH+1)-1, so cin=0 is swept first.
- Golden value is {cout,sum} = a + b + cin, computed at width WIDTH+1. A mismatch is any difference in either field.
- FSM states:
  - IDLE: outputs hold. start=1 clears err_count, fail_valid, fail_vec, done and pass; sets vec=0, busy=1, wait counter=SETTLE; next state DRIVE.
  - DRIVE: wait counter decrements each cycle; when it reaches 1, next state CHECK.
  - CHECK: one cycle. Compare the inputs against golden. On mismatch, err_count increments. On the first mismatch only, fail_vec<=vec and fail_valid<=1.
    - If vec is all-ones: next state DONE, busy=0, done=1, pass=(final err_count==0).
    - Otherwise: vec increments, wait counter reloads to SETTLE, next state DRIVE.
  - DONE: outputs hold. start=1 behaves exactly as in IDLE (restart).
- start is ignored while busy=1.
- err_count width 2*WIDTH+2 holds the full vector count (32 for WIDTH=2); no saturation logic is required.
- Reset mid-sweep aborts immediately. No partial results are retained.

## Timing
- Reset values: test_a=0, test_b=0, test_cin=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0. FSM is in IDLE.
- The start edge is E0. busy=1 and vec=0 are visible after E0.
- Each vector occupies SETTLE+1 cycles. Adder inputs are stable for the full SETTLE+1 cycles before the sampling edge, which absorbs a registered or pipelined adder of latency up to SETTLE.
- done rises, and busy falls, after edge E0 + 2^(2*WIDTH+1)*(SETTLE+1). For WIDTH=2, SETTLE=1 this is 64 cycles.
- err_count and fail_vec update on the CHECK edge. pass becomes valid in the same cycle done rises and is never 1 while busy.
- Outputs are registered; there is no combinational path from dut_sum/dut_cout to any output.

## Test plan
- Correct adder, WIDTH=2, SETTLE=1, start pulse -> busy for 64 cycles, then done=1, pass=1, err_count=0, fail_valid=0. test_* visit all 32 vectors in order.
- Adder with Carry_out stuck-at-0 -> done after 64 cycles, pass=0, err_count=16, fail_valid=1, fail_vec=7 (cin=0, a=1, b=3).
- Adder with Sum[0] stuck-at-0 -> err_count=16, fail_vec=1 (cin=0, a=0, b=1), pass=0.
- rst_n low at cycle 20 of a sweep -> all outputs 0 asynchronously. A new start then gives a full 64-cycle sweep with correct counts.
- start re-pulsed at cycle 10 while busy -> ignored; done still at cycle 64. start in DONE with err_count=16 -> counts cleared, and a fresh sweep with the correct adder ends pass=1.
- SETTLE=3, adder model with 2-cycle registered output -> done after 128 cycles, pass=1, err_count=0.
